// File: rtl/y86_fetch_exec_mem.sv
// Y86-64 fetch, execute and memory stages: one instruction is decoded from a PC,
// valE and cnd come out of the ALU, and the 8-byte data-memory access is made.
module y86_fetch_exec_mem #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] PC,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error,
    output logic        hlt,
    output logic [63:0] valE,
    output logic        cnd,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic [63:0] valM,
    output logic        dmem_error
);
    localparam int IAW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam int DAW = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

    logic [7:0]  imem [IMEM_BYTES];
    logic [7:0]  dmem [DMEM_BYTES];

    logic [7:0]  fb [10];
    logic [64:0] fa;
    logic [3:0]  raw_icode;
    logic [3:0]  raw_ifun;
    logic [3:0]  len;
    logic        has_reg;
    logic        valc_at1;
    logic        valc_at2;
    logic [64:0] fetch_end;
    logic        raw_valid;

    // Bytes beyond the end of instruction memory read as zero; imem_error flags them.
    always_comb begin
        fa = '0;
        for (int i = 0; i < 10; i++) begin
            fa    = {1'b0, PC} + 65'(i);
            fb[i] = (fa < 65'(IMEM_BYTES)) ? imem[fa[IAW-1:0]] : 8'h00;
        end
    end

    assign raw_icode = fb[0][7:4];
    assign raw_ifun  = fb[0][3:0];

    always_comb begin
        len      = 4'd1;
        has_reg  = 1'b0;
        valc_at1 = 1'b0;
        valc_at2 = 1'b0;
        case (raw_icode)
            4'h2, 4'h6, 4'hA, 4'hB: begin
                len     = 4'd2;
                has_reg = 1'b1;
            end
            4'h3, 4'h4, 4'h5: begin
                len      = 4'd10;
                has_reg  = 1'b1;
                valc_at2 = 1'b1;
            end
            4'h7, 4'h8: begin
                len      = 4'd9;
                valc_at1 = 1'b1;
            end
            default: len = 4'd1;
        endcase
    end

    always_comb begin
        raw_valid = 1'b0;
        case (raw_icode)
            4'h2, 4'h7: raw_valid = (raw_ifun <= 4'h6);
            4'h6:       raw_valid = (raw_ifun <= 4'h3);
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                        raw_valid = (raw_ifun == 4'h0);
            default:    raw_valid = 1'b0;
        endcase
    end

    assign fetch_end  = {1'b0, PC} + 65'(len) - 65'd1;
    assign imem_error = (fetch_end >= 65'(IMEM_BYTES));
    assign valP       = PC + 64'(len);

    // A fetch that runs off memory is presented downstream as a harmless nop.
    always_comb begin
        icode       = raw_icode;
        ifun        = raw_ifun;
        rA          = 4'hF;
        rB          = 4'hF;
        valC        = '0;
        instr_valid = raw_valid;
        if (has_reg) begin
            rA = fb[1][7:4];
            rB = fb[1][3:0];
        end
        if (valc_at2)
            valC = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
        else if (valc_at1)
            valC = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
        if (imem_error) begin
            icode       = 4'h1;
            ifun        = 4'h0;
            rA          = 4'hF;
            rB          = 4'hF;
            valC        = '0;
            instr_valid = 1'b0;
        end
    end

    assign hlt = (icode == 4'h0);

    logic [63:0] op_res;
    logic        op_of;

    always_comb begin
        op_res = '0;
        op_of  = 1'b0;
        case (ifun)
            4'h0: begin
                op_res = valB + valA;
                op_of  = (valA[63] == valB[63]) && (op_res[63] != valB[63]);
            end
            4'h1: begin
                op_res = valB - valA;
                op_of  = (valA[63] != valB[63]) && (op_res[63] != valB[63]);
            end
            4'h2:    op_res = valB & valA;
            4'h3:    op_res = valB ^ valA;
            default: op_res = '0;
        endcase
    end

    always_comb begin
        valE = '0;
        case (icode)
            4'h2:       valE = valA;
            4'h3:       valE = valC;
            4'h4, 4'h5: valE = valB + valC;
            4'h6:       valE = op_res;
            4'h8, 4'hA: valE = valB - 64'd8;
            4'h9, 4'hB: valE = valB + 64'd8;
            default:    valE = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b0;
            sf <= 1'b0;
            of <= 1'b0;
        end else if (icode == 4'h6 && instr_valid && !imem_error) begin
            zf <= (op_res == 64'd0);
            sf <= op_res[63];
            of <= op_of;
        end
    end

    always_comb begin
        cnd = 1'b0;
        if (icode == 4'h2 || icode == 4'h7) begin
            case (ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (sf ^ of) | zf;
                4'h2:    cnd = sf ^ of;
                4'h3:    cnd = zf;
                4'h4:    cnd = ~zf;
                4'h5:    cnd = ~(sf ^ of);
                4'h6:    cnd = ~(sf ^ of) & ~zf;
                default: cnd = 1'b0;
            endcase
        end
    end

    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [DAW-1:0] da;

    assign mem_rd    = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
    assign mem_wr    = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
    assign mem_addr  = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
    assign mem_wdata = (icode == 4'h8) ? valP : valA;
    assign da        = mem_addr[DAW-1:0];
    assign dmem_error = (mem_rd || mem_wr) &&
                        (({1'b0, mem_addr} + 65'd7) >= 65'(DMEM_BYTES));

    // Index arithmetic cannot wrap: dmem_error guarantees the 8 bytes fit.
    always_comb begin
        valM = '0;
        if (mem_rd && !dmem_error) begin
            for (int k = 0; k < 8; k++)
                valM[8*k +: 8] = dmem[da + DAW'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr && instr_valid && !imem_error && !dmem_error) begin
            for (int k = 0; k < 8; k++)
                dmem[da + DAW'(k)] <= mem_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (imem_we && (imem_waddr < 64'(IMEM_BYTES)))
            imem[imem_waddr[IAW-1:0]] <= imem_wdata;
    end

endmodule

// File: tb/tb_y86_fetch_exec_mem.sv
// Directed bench for y86_fetch_exec_mem: loads a small program image, then
// steps through fetch, ALU, condition-code and data-memory cases.
module tb_y86_fetch_exec_mem;
    logic        clk;
    logic        rst_n;
    logic [63:0] PC;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;
    logic        hlt;
    logic [63:0] valE;
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;
    logic [63:0] valM;
    logic        dmem_error;

    int checks = 0;
    int errors = 0;

    y86_fetch_exec_mem #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .valA(valA), .valB(valB),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error), .hlt(hlt),
        .valE(valE), .cnd(cnd), .zf(zf), .sf(sf), .of(of),
        .valM(valM), .dmem_error(dmem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [63:0] a, input logic [7:0] b);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = b;
        tick();
        imem_we    = 1'b0;
    endtask

    // v holds byte 0 in its low bits.
    task automatic wr_instr(input logic [63:0] a, input int n, input logic [79:0] v);
        for (int i = 0; i < n; i++)
            load_byte(a + 64'(i), v[8*i +: 8]);
    endtask

    task automatic at(input logic [63:0] p, input logic [63:0] a, input logic [63:0] b);
        PC   = p;
        valA = a;
        valB = b;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; PC = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        valA = '0; valB = '0;
        #3;
        chk("rst_zf", 64'(zf), 64'd0);
        chk("rst_sf", 64'(sf), 64'd0);
        chk("rst_of", 64'(of), 64'd0);

        wr_instr(64'd0,  10, {64'd10, 8'hF3, 8'h30});   // irmovq $10,%rbx
        wr_instr(64'd10, 2,  {64'd0,  8'h23, 8'h61});   // subq
        wr_instr(64'd12, 2,  {64'd0,  8'h23, 8'h60});   // addq
        wr_instr(64'd14, 1,  {72'd0,  8'h00});          // halt
        wr_instr(64'd15, 1,  {72'd0,  8'hC0});          // illegal
        wr_instr(64'd20, 9,  {8'h0, 64'h40, 8'h80});    // call
        wr_instr(64'd30, 9,  {8'h0, 64'h0,  8'h73});    // je
        wr_instr(64'd39, 9,  {8'h0, 64'h0,  8'h74});    // jne
        wr_instr(64'd48, 9,  {8'h0, 64'h0,  8'h72});    // jl
        wr_instr(64'd57, 9,  {8'h0, 64'h0,  8'h71});    // jle
        wr_instr(64'd66, 9,  {8'h0, 64'h0,  8'h76});    // jg
        wr_instr(64'd75, 10, {64'd8, 8'h12, 8'h40});    // rmmovq
        wr_instr(64'd85, 10, {64'd8, 8'h12, 8'h50});    // mrmovq
        wr_instr(64'd95, 2,  {64'd0, 8'h1F, 8'hA0});    // pushq
        wr_instr(64'd97, 2,  {64'd0, 8'h1F, 8'hB0});    // popq
        wr_instr(64'd1014, 1, {72'd0, 8'h30});
        wr_instr(64'd1019, 1, {72'd0, 8'h30});
        rst_n = 1'b1;

        at(64'd0, 64'd0, 64'd0);
        chk("irmov_icode", 64'(icode), 64'h3);
        chk("irmov_rA", 64'(rA), 64'hF);
        chk("irmov_rB", 64'(rB), 64'h3);
        chk("irmov_valC", valC, 64'd10);
        chk("irmov_valP", valP, 64'd10);
        chk("irmov_valE", valE, 64'd10);
        chk("irmov_valid", 64'(instr_valid), 64'd1);

        at(64'd10, 64'd5, 64'd5);
        chk("sub_valE", valE, 64'd0);
        chk("sub_zf_pre", 64'(zf), 64'd0);
        tick();
        chk("sub_zf", 64'(zf), 64'd1);
        chk("sub_sf", 64'(sf), 64'd0);
        chk("sub_of", 64'(of), 64'd0);
        at(64'd30, 64'd0, 64'd0);
        chk("je_cnd", 64'(cnd), 64'd1);
        chk("je_valP", valP, 64'd39);
        at(64'd39, 64'd0, 64'd0);
        chk("jne_cnd", 64'(cnd), 64'd0);

        at(64'd30, 64'd0, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_zf", 64'(zf), 64'd0);
        chk("midrst_je_cnd", 64'(cnd), 64'd0);
        rst_n = 1'b1;

        at(64'd12, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("add_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        chk("add_sf", 64'(sf), 64'd1);
        chk("add_of", 64'(of), 64'd1);
        chk("add_zf", 64'(zf), 64'd0);
        at(64'd48, 64'd0, 64'd0);
        chk("jl_cnd", 64'(cnd), 64'd0);
        at(64'd57, 64'd0, 64'd0);
        chk("jle_cnd", 64'(cnd), 64'd0);
        at(64'd66, 64'd0, 64'd0);
        chk("jg_cnd", 64'(cnd), 64'd1);

        at(64'd75, 64'h1122_3344_5566_7788, 64'd16);
        chk("rmmov_valE", valE, 64'd24);
        chk("rmmov_derr", 64'(dmem_error), 64'd0);
        tick();
        at(64'd85, 64'd0, 64'd16);
        chk("mrmov_valE", valE, 64'd24);
        chk("mrmov_valM", valM, 64'h1122_3344_5566_7788);
        chk("mrmov_derr", 64'(dmem_error), 64'd0);

        at(64'd95, 64'hCAFE_F00D_0000_0001, 64'd100);
        chk("push_valE", valE, 64'd92);
        chk("push_valP", valP, 64'd97);
        tick();
        at(64'd97, 64'd92, 64'd100);
        chk("pop_valE", valE, 64'd108);
        chk("pop_valM", valM, 64'hCAFE_F00D_0000_0001);

        at(64'd20, 64'd0, 64'd200);
        chk("call_valE", valE, 64'd192);
        chk("call_valP", valP, 64'd29);
        chk("call_valC", valC, 64'h40);
        tick();
        at(64'd85, 64'd0, 64'd184);
        chk("call_ret_addr", valM, 64'd29);

        at(64'd85, 64'd0, 64'd1008);
        chk("dmem_edge_ok", 64'(dmem_error), 64'd0);
        at(64'd85, 64'd0, 64'd1009);
        chk("dmem_edge_err", 64'(dmem_error), 64'd1);
        chk("dmem_err_valM", valM, 64'd0);

        at(64'd14, 64'd0, 64'd0);
        chk("halt_hlt", 64'(hlt), 64'd1);
        chk("halt_valP", valP, 64'd15);
        chk("halt_valid", 64'(instr_valid), 64'd1);
        at(64'd15, 64'd0, 64'd0);
        chk("illegal_valid", 64'(instr_valid), 64'd0);

        at(64'd1014, 64'd0, 64'd0);
        chk("imem_edge_ok", 64'(imem_error), 64'd0);
        at(64'd1019, 64'd0, 64'd0);
        chk("imem_err", 64'(imem_error), 64'd1);
        chk("imem_err_icode", 64'(icode), 64'h1);
        chk("imem_err_valid", 64'(instr_valid), 64'd0);

        at(64'd0, 64'd0, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("endrst_sf", 64'(sf), 64'd0);
        chk("endrst_of", 64'(of), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
